// File: rtl/native_rr_arbiter_pkg.sv
// Shared types and width helpers for the native round-robin arbiter.
package native_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of an index into n masters; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Width of the timeout counter; a disabled timeout still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/native_rr_arbiter_if.sv
// Native valid/ready bus with N request lanes and a shared read-data return.
interface native_rr_arbiter_if #(
    parameter int unsigned N  = 1,
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32,
    parameter int unsigned SW = DW / 8
);
    logic [N-1:0]    valid;
    logic [N-1:0]    ready;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [N*SW-1:0] wstrb;
    logic [DW-1:0]   rdata;

    modport master (
        output valid, addr, wdata, wstrb,
        input  ready, rdata
    );

    modport slave (
        input  valid, addr, wdata, wstrb,
        output ready, rdata
    );
endinterface

// File: rtl/native_rr_arbiter_pick.sv
// Combinational round-robin priority encoder: first request at or after ptr_i, with wrap.
module native_rr_pick
    import native_rr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [2*N-1:0] dbl;

    // Lower copy masked below the pointer; the upper copy supplies the wrap-around.
    always_comb begin
        dbl = {req_i, req_i};
        for (int k = 0; k < int'(N); k++) begin
            if (k < int'(ptr_i)) begin
                dbl[k] = 1'b0;
            end
        end
        idx_o = '0;
        for (int k = 2 * int'(N) - 1; k >= 0; k--) begin
            if (dbl[k]) begin
                idx_o = (k >= int'(N)) ? IW'(k - int'(N)) : IW'(k);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/native_rr_arbiter.sv
// Round-robin arbiter sharing one native slave among N native masters, with optional timeout.
module native_rr_arbiter
    import native_rr_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS  = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    native_rr_arbiter_if.slave                m_bus,
    native_rr_arbiter_if.master               s_bus,
    output logic [idx_width(N_MASTERS)-1:0]   grant_id,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int unsigned IW = idx_width(N_MASTERS);
    localparam int unsigned TW = cnt_width(TIMEOUT);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  grant_q, grant_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    logic [IW-1:0]  pick_idx;
    logic           pick_any;
    logic           s_ready;
    logic           gnt_valid;
    logic           tmo_hit;
    logic [IW-1:0]  ptr_after;

    logic                  s_valid;
    logic [N_MASTERS-1:0]  m_ready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic [STRB_WIDTH-1:0] s_wstrb;

    native_rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req_i (m_bus.valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign s_ready   = s_bus.ready[0];
    assign gnt_valid = m_bus.valid[grant_q];
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
    assign ptr_after = (grant_q == IW'(N_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state: any termination (completion, withdrawal, timeout) advances the pointer.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    tmo_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (s_ready || !gnt_valid || tmo_hit) begin
                    state_d  = IDLE;
                    rr_ptr_d = ptr_after;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    // Outputs: slave response beats withdrawal and timeout; withdrawal beats timeout.
    always_comb begin
        busy        = 1'b0;
        s_valid     = 1'b0;
        m_ready     = '0;
        m_rdata     = '0;
        s_addr      = '0;
        s_wdata     = '0;
        s_wstrb     = '0;
        timeout_err = 1'b0;
        if (state_q == BUSY) begin
            busy    = 1'b1;
            s_addr  = m_bus.addr[int'(grant_q) * ADDR_WIDTH +: ADDR_WIDTH];
            s_wdata = m_bus.wdata[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
            s_wstrb = m_bus.wstrb[int'(grant_q) * STRB_WIDTH +: STRB_WIDTH];
            m_rdata = s_bus.rdata;
            if (s_ready) begin
                m_ready[grant_q] = 1'b1;
                s_valid          = gnt_valid;
            end else if (gnt_valid && tmo_hit) begin
                m_ready[grant_q] = 1'b1;
                m_rdata          = '0;
                timeout_err      = 1'b1;
            end else begin
                s_valid = gnt_valid;
            end
        end
    end

    assign grant_id    = grant_q;
    assign m_bus.ready = m_ready;
    assign m_bus.rdata = m_rdata;
    assign s_bus.valid = 1'(s_valid);
    assign s_bus.addr  = s_addr;
    assign s_bus.wdata = s_wdata;
    assign s_bus.wstrb = s_wstrb;

endmodule

// File: tb/tb_native_rr_arbiter.sv
// Bench for native_rr_arbiter: directed scenarios plus random traffic against a cycle model.
module tb_native_rr_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned SW  = 4;
    localparam int unsigned TMO = 8;

    logic       clk;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    logic       timeout_err;

    native_rr_arbiter_if #(.N(N), .AW(AW), .DW(DW), .SW(SW)) m_bus ();
    native_rr_arbiter_if #(.N(1), .AW(AW), .DW(DW), .SW(SW)) s_bus ();

    native_rr_arbiter #(
        .N_MASTERS  (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .STRB_WIDTH (SW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_bus       (m_bus),
        .s_bus       (s_bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit         mdl_busy = 1'b0;
    int         mdl_grant = 0;
    int         mdl_ptr = 0;
    int         mdl_tmo = 0;
    logic [N-1:0] last_ready = '0;
    int         dut_log[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_master(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_bus.addr[i*AW +: AW]  = a;
        m_bus.wdata[i*DW +: DW] = d;
        m_bus.wstrb[i*SW +: SW] = s;
    endtask

    // One clock: compare every output to the model mid-cycle, then advance the model.
    task automatic step();
        logic [N-1:0]  e_ready;
        logic [31:0]   e_rdata, e_addr, e_wdata;
        logic [3:0]    e_wstrb;
        logic          e_svalid, e_terr, gv, done, found;
        int            k;
        @(negedge clk);
        e_ready = '0; e_rdata = '0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        e_svalid = 1'b0; e_terr = 1'b0; done = 1'b0; gv = 1'b0;
        if (mdl_busy) begin
            gv      = m_bus.valid[mdl_grant];
            e_addr  = m_bus.addr[mdl_grant*AW +: AW];
            e_wdata = m_bus.wdata[mdl_grant*DW +: DW];
            e_wstrb = m_bus.wstrb[mdl_grant*SW +: SW];
            e_rdata = s_bus.rdata;
            if (s_bus.ready[0]) begin
                e_ready[mdl_grant] = 1'b1;
                e_svalid = gv;
                done = 1'b1;
            end else if (!gv) begin
                done = 1'b1;
            end else if (mdl_tmo == int'(TMO) - 1) begin
                e_ready[mdl_grant] = 1'b1;
                e_terr  = 1'b1;
                e_rdata = '0;
                done    = 1'b1;
            end else begin
                e_svalid = 1'b1;
            end
        end
        check_val("busy",     64'(busy),         64'(mdl_busy));
        check_val("grant_id", 64'(grant_id),     64'(mdl_grant));
        check_val("s_valid",  64'(s_bus.valid),  64'(e_svalid));
        check_val("m_ready",  64'(m_bus.ready),  64'(e_ready));
        check_val("m_rdata",  64'(m_bus.rdata),  64'(e_rdata));
        check_val("s_addr",   64'(s_bus.addr),   64'(e_addr));
        check_val("s_wdata",  64'(s_bus.wdata),  64'(e_wdata));
        check_val("s_wstrb",  64'(s_bus.wstrb),  64'(e_wstrb));
        check_val("tmo_err",  64'(timeout_err),  64'(e_terr));
        for (int i = 0; i < int'(N); i++) begin
            if (m_bus.ready[i]) dut_log.push_back(i);
        end
        last_ready = e_ready;
        @(posedge clk);
        #1;
        if (rst) begin
            mdl_busy = 1'b0; mdl_grant = 0; mdl_ptr = 0; mdl_tmo = 0;
        end else if (mdl_busy) begin
            if (done) begin
                mdl_busy = 1'b0;
                mdl_ptr  = (mdl_grant + 1) % int'(N);
            end else begin
                mdl_tmo++;
            end
        end else begin
            found = 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                k = (mdl_ptr + i) % int'(N);
                if (!found && m_bus.valid[k]) begin
                    found = 1'b1;
                    mdl_grant = k;
                    mdl_busy = 1'b1;
                    mdl_tmo = 0;
                end
            end
        end
    endtask

    task automatic run_random(input int cycles, input int rdy_pct, input int wd_pct);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (last_ready[i])
                    m_bus.valid[i] = ($urandom_range(1, 0) == 1);
                else if (!m_bus.valid[i])
                    m_bus.valid[i] = (int'($urandom_range(99, 0)) < 40);
                else if (mdl_busy && mdl_grant == i && int'($urandom_range(99, 0)) < wd_pct)
                    m_bus.valid[i] = 1'b0;
                set_master(i, $urandom, $urandom, 4'($urandom));
            end
            s_bus.ready[0] = (int'($urandom_range(99, 0)) < rdy_pct);
            s_bus.rdata    = $urandom;
            step();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5];
        bit found;
        exp_order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        m_bus.valid = '0; m_bus.addr = '0; m_bus.wdata = '0; m_bus.wstrb = '0;
        s_bus.ready = '0; s_bus.rdata = '0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check_val("rst_busy",   64'(busy),        64'd0);
        check_val("rst_svalid", 64'(s_bus.valid), 64'd0);
        check_val("rst_grant",  64'(grant_id),    64'd0);

        // Single master write, slave answers on the fourth BUSY cycle
        set_master(1, 32'h40, 32'hDEAD_BEEF, 4'hF);
        m_bus.valid = 4'b0010;
        step();
        check_val("single_svalid", 64'(s_bus.valid), 64'd1);
        check_val("single_saddr",  64'(s_bus.addr),  64'h40);
        check_val("single_swdata", 64'(s_bus.wdata), 64'hDEAD_BEEF);
        check_val("single_swstrb", 64'(s_bus.wstrb), 64'hF);
        step(); step(); step();
        s_bus.ready[0] = 1'b1;
        #1;
        check_val("single_mready", 64'(m_bus.ready), 64'b0010);
        step();
        s_bus.ready[0] = 1'b0;
        m_bus.valid = 4'b1111;
        step();
        // Pointer now sits past master 1
        check_val("single_next_grant", 64'(grant_id), 64'd2);

        // Fairness with every master requesting and an always-ready slave
        do_reset();
        m_bus.valid = 4'b1111;
        s_bus.ready[0] = 1'b1;
        dut_log.delete();
        for (int i = 0; i < 10; i++) step();
        check_val("fair_count", 64'(dut_log.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check_val("fair_order", 64'((i < dut_log.size()) ? dut_log[i] : -1), 64'(exp_order[i]));

        // Read returns slave data in the completion cycle
        s_bus.ready[0] = 1'b0;
        m_bus.valid = 4'b0100;
        set_master(2, 32'h1000, 32'h0, 4'h0);
        step();
        s_bus.ready[0] = 1'b1;
        s_bus.rdata = 32'h1234_5678;
        #1;
        check_val("rd_rdata", 64'(m_bus.rdata), 64'h1234_5678);
        check_val("rd_ready", 64'(m_bus.ready), 64'b0100);
        step();

        // Silent slave: forced completion on the eighth BUSY cycle
        s_bus.ready[0] = 1'b0;
        m_bus.valid = 4'b0010;
        step();
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            s_bus.rdata = $urandom | 32'h1;
            #1;
            if (timeout_err) begin
                found = 1'b1;
                check_val("tmo_cycle", 64'(c), 64'(TMO));
                check_val("tmo_rdata", 64'(m_bus.rdata), 64'd0);
                check_val("tmo_ready", 64'(m_bus.ready), 64'b0010);
            end
            step();
        end
        if (!found) check_val("tmo_seen", 64'd0, 64'd1);
        #1;
        check_val("tmo_idle", 64'(busy), 64'd0);

        // Slave answers exactly on the timeout cycle: normal completion
        step();
        for (int c = 1; c < int'(TMO); c++) step();
        s_bus.ready[0] = 1'b1;
        #1;
        check_val("tmo_race_err",   64'(timeout_err), 64'd0);
        check_val("tmo_race_ready", 64'(m_bus.ready), 64'b0010);
        step();
        s_bus.ready[0] = 1'b0;

        // Granted master withdraws mid-transaction
        m_bus.valid = 4'b0111;
        step();
        step();
        m_bus.valid = 4'b0011;
        #1;
        check_val("wd_svalid", 64'(s_bus.valid), 64'd0);
        check_val("wd_ready",  64'(m_bus.ready), 64'd0);
        step();
        step();
        check_val("wd_next_grant", 64'(grant_id), 64'd0);

        // Reset while BUSY; a late slave response is ignored
        m_bus.valid = 4'b1111;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        s_bus.ready[0] = 1'b1;
        #1;
        check_val("rstb_busy",   64'(busy),        64'd0);
        check_val("rstb_svalid", 64'(s_bus.valid), 64'd0);
        check_val("rstb_ready",  64'(m_bus.ready), 64'd0);
        check_val("rstb_err",    64'(timeout_err), 64'd0);
        step();
        check_val("rstb_first_grant", 64'(grant_id), 64'd0);
        s_bus.ready[0] = 1'b0;

        // Random traffic: responsive, sluggish, and near-silent slave
        do_reset();
        run_random(800, 60, 3);
        run_random(800, 15, 3);
        run_random(800, 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/native_rr_arbiter.md
# native_rr_arbiter

Round-robin arbiter that shares one native-interface slave (valid/ready/addr/wdata/wstrb/rdata) among N native masters. It sits between several native requesters, such as CPU ports or AXI4-lite-to-native adapters, and a single native memory or peripheral. It grants one master at a time and holds that grant until the slave completes the transaction. An optional timeout frees the bus if the slave never answers.

## Interface
- N_MASTERS, 2: number of requesting masters (≥2).
- DATA_WIDTH, 32: data bus width in bits.
- ADDR_WIDTH, 32: address bus width in bits.
- STRB_WIDTH, DATA_WIDTH/8: write-strobe width; wstrb=0 means read.
- TIMEOUT, 0: cycles in BUSY before a forced completion; 0 disables the timeout.
- clk  in  1  single clock, rising edge. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- m_valid  in  N_MASTERS  per-master request.
- m_ready  out  N_MASTERS  per-master completion pulse.
- m_addr  in  N_MASTERS*ADDR_WIDTH  master i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_wdata  in  N_MASTERS*DATA_WIDTH  packed the same way.
- m_wstrb  in  N_MASTERS*STRB_WIDTH  packed the same way.
- m_rdata  out  DATA_WIDTH  shared read data; valid only with the m_ready bit.
- s_valid  out  1  slave request.
- s_ready  in  1  slave completion, one-cycle pulse.
- s_addr / s_wdata / s_wstrb  out  ADDR_WIDTH / DATA_WIDTH / STRB_WIDTH  muxed from the granted master.
- s_rdata  in  DATA_WIDTH  slave read data.
- grant_id  out  max(1,$clog2(N_MASTERS))  index of the current or last grant.
- busy  out  1  high in state BUSY.
- timeout_err  out  1  one-cycle pulse on a forced completion.

## Operation
- Two-state FSM.
- IDLE:
  - s_valid=0.
  - If any m_valid bit is set, pick the first set bit at or after rr_ptr, scanning upward with wrap.
  - Register that index into grant_id and move to BUSY.
- BUSY:
  - s_valid = m_valid[grant_id].
  - s_addr, s_wdata and s_wstrb are combinationally selected from the granted master.
  - m_rdata = s_rdata.
- BUSY and s_ready=1:
  - m_ready[grant_id]=1 in the same cycle.
  - rr_ptr ← grant_id+1, wrapping to 0 after N_MASTERS-1.
  - Next state IDLE.
- BUSY, m_valid[grant_id]=0 (the master withdrew, which is a protocol violation):
  - s_valid drops the same cycle.
  - Next state IDLE with no m_ready and rr_ptr advanced.
  - If s_ready coincides with the withdrawal, s_ready wins and the transaction completes normally.
- Timeout (TIMEOUT>0):
  - tmo_cnt clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When tmo_cnt reaches TIMEOUT-1 without s_ready: m_ready[grant_id]=1, m_rdata=0, timeout_err=1, s_valid=0, next state IDLE.
  - s_ready in that same cycle takes precedence (normal completion, no error).
  - tmo_cnt width is $clog2(TIMEOUT+1).
- s_ready outside BUSY is ignored: no m_ready is generated.
- All m_ready bits other than the granted one stay 0 at all times.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_id 0, tmo_cnt 0.
  - Outputs: s_valid 0, m_ready all 0, busy 0, timeout_err 0.
  - s_addr, s_wdata and s_wstrb drive 0 while not BUSY.
  - m_rdata 0 outside BUSY.
- Arbitration latency is 1 cycle: m_valid seen in IDLE at cycle t gives s_valid=1 at t+1.
- Completion is combinational: s_ready at cycle k gives m_ready at cycle k and IDLE at k+1.
- Minimum 2 cycles per transaction. A requester held valid is re-arbitrated at k+1 and granted at k+2.
- Fairness: with all N requesting, each master completes exactly once in every N transactions.
- Reset mid-transaction returns to IDLE the next edge with s_valid=0. The in-flight slave response is dropped.

## Structure
- Shared header: FSM state encodings (IDLE=1'b0, BUSY=1'b1).
- One sub-module, native_rr_pick: combinational round-robin priority encoder.
  - Inputs: request vector and pointer.
  - Outputs: index and any-request flag.
  - Implemented as a double-width masked scan.
- The top level holds the FSM, rr_ptr, the grant register, the timeout counter and the muxes.

## Test plan
- **Single master:** N=2; m_valid[1]=1, addr=0x40, wstrb=0xF, wdata=0xDEADBEEF; slave asserts s_ready 3 cycles after s_valid. Expect s_valid at t+1, s_addr=0x40, m_ready[1] only, and rr_ptr=0 afterwards.
- **Fairness:** N=4, all m_valid held at 1, slave always ready. Expect grant order 0,1,2,3,0, each transaction taking 2 cycles, with m_ready never set for a non-granted master.
- **Read data:** master 2 reads (wstrb=0) and the slave returns s_rdata=0x12345678 with s_ready. Expect m_rdata=0x12345678 in the same cycle as m_ready[2].
- **Timeout:** TIMEOUT=8 and the slave never responds. Expect m_ready[grant] and timeout_err on the 8th BUSY cycle, with m_rdata=0 and IDLE next. Also check that s_ready and the timeout in the same cycle give a normal completion with no timeout_err.
- **Withdrawal:** the granted master drops m_valid mid-BUSY. Expect s_valid=0 the same cycle, no m_ready, and the next master granted.
- **Reset:** assert rst while BUSY. Expect all outputs at their reset values the next cycle. A late s_ready is ignored, and the first grant after reset goes to master 0.
